tick_timer_arbiter: RTL and testbench
=====================================

// Module: tick_timer_arbiter
// PURPOSE
//  Shares one enable-gated modulo tick counter among NREQ requesters. Each requester asks for a
//  delay of LEN ticks. The block grants the counter to one requester at a time, round-robin.
//  It runs the count, then pulses done to the owner. Sits between the control FSMs and the tick
//  prescaler, so only one interval-timing datapath is needed.
// PARAMETERS
//  NREQ      4  number of requesters (2..8)
//  CNT_WIDTH 4  width of each requested length and of the count
//  IDW       2  width of owner id, = clog2(NREQ)
// PORTS
//  clk        in   1              rising-edge clock
//  reset_n    in   1              async active-low reset
//  tick_en    in   1              count-enable strobe from the prescaler
//  req        in   NREQ           level request, one bit per requester
//  req_len    in   NREQ*CNT_WIDTH LEN of requester i at [i*CNT_WIDTH +: CNT_WIDTH]
//  grant      out  NREQ           one-hot owner, registered
//  busy       out  1              1 while in GRANT/RUN/DONE
//  count_out  out  CNT_WIDTH      current count of the owner's interval
//  done       out  1              one-cycle pulse: interval finished
//  done_id    out  IDW            owner index, valid while done=1
// BEHAVIOUR
//  Reset: all outputs are 0; state is IDLE; priority pointer ptr=0.
//  FSM states: IDLE, GRANT, RUN, DONE.
//  IDLE
//   - If any req bit is high, pick the first set bit searching from ptr upward, with wrap.
//   - Latch the winner's LEN into len_q. LEN=0 is treated as 1.
//   - Set grant one-hot and go to GRANT. grant is visible 1 cycle after req is sampled.
//  GRANT (1 cycle)
//   - Clear count_out to 0 and go to RUN. tick_en is ignored in this state.
//  RUN
//   - On tick_en, if count_out == len_q-1, go to DONE. Otherwise count_out increments by 1.
//   - Without tick_en, count_out holds.
//   - count_out wraps to 0 on exit. It never reaches len_q.
//  DONE (1 cycle)
//   - done=1, done_id=owner. grant is still asserted.
//   - ptr <= owner+1, mod NREQ.
//   - Next state is IDLE; grant and count_out clear to 0.
//  Abort
//   - If the owner's req drops in GRANT or RUN, go to IDLE next cycle.
//   - No done pulse is issued, and ptr still advances past the owner.
//  Other rules
//   - The owner must hold req until it sees done, then drop it.
//   - A req still high in IDLE after its own DONE is re-arbitrated. Because ptr has advanced,
//     other requesters win first.
//   - req/req_len changes of non-owners never disturb the current run.
//   - The owner's req_len is latched at grant. Later changes are ignored.
//   - Interval duration = LEN tick_en strobes in RUN. Grant-to-done is at least LEN+1 cycles
//     when tick_en is tied to 1.
//   - Reset mid-run: outputs clear asynchronously. No done pulse is issued.
//   - The count is unsigned CNT_WIDTH arithmetic with no saturation. len_q-1 is computed
//     after the LEN=0 to 1 mapping.
//   - Idle gap: at least one IDLE cycle between consecutive grants.
// STRUCTURE
//  Package tick_timer_pkg holds:
//   - the state enum localparams (S_IDLE=2'd0, S_GRANT=2'd1, S_RUN=2'd2, S_DONE=2'd3);
//   - a function onehot2idx.
//  Sub-module rr_arbiter #(NREQ):
//   - combinational pick of the first set request from ptr, with wrap;
//   - outputs gnt_onehot, gnt_idx, any.
//  Top level holds the FSM, ptr, len_q, the counter and the output registers.
// TESTING
//  1 Single request: tick_en=1, req=4'b0001, LEN0=3
//    -> grant=0001 one cycle later; count 0,1,2; done with done_id=0;
//       grant-to-done = 4 cycles.
//  2 Contention: req=4'b1010 held, LEN1=LEN3=2, from reset
//    -> grant order 1, 3, 1, 3; done_id alternates 1, 3; never two grant bits set.
//  3 Tick gating: LEN=5, tick_en every 3rd cycle
//    -> count steps only on strobes; done after the 5th strobe in RUN.
//  4 LEN=0
//    -> behaves exactly as LEN=1: one strobe, then done.
//  5 Abort: owner drops req at count=2 of LEN=8
//    -> IDLE next cycle, no done, grant=0; next grant goes to the following requester.
//  6 Reset mid-RUN: reset_n=0 at count=4
//    -> grant, busy, done, count_out are 0 immediately; after release, ptr=0 and arbitration
//       restarts from requester 0.

Source files
------------

// File: rtl/tick_timer_arbiter_pkg.sv
// Shared types and helpers for the tick timer arbiter: FSM state encoding
// and a one-hot to index encoder used by the round-robin picker.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Widest requester vector the encoder supports.
  localparam int MAX_NREQ = 8;

  // Encode a one-hot (or all-zero) vector into the index of its set bit.
  function automatic logic [2:0] onehot2idx(input logic [MAX_NREQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      idx = idx | ({3{oh[i]}} & 3'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/tick_timer_arbiter_if.sv
// Request/grant bundle between the control FSMs (master) and the shared
// tick timer (slave). Clock and reset travel as plain ports.
interface tick_timer_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int CNT_WIDTH = 4,
  parameter int IDW       = 2
);
  logic                      tick_en;
  logic [NREQ-1:0]           req;
  logic [NREQ*CNT_WIDTH-1:0] req_len;
  logic [NREQ-1:0]           grant;
  logic                      busy;
  logic [CNT_WIDTH-1:0]      count_out;
  logic                      done;
  logic [IDW-1:0]            done_id;

  modport master (
    output tick_en, req, req_len,
    input  grant, busy, count_out, done, done_id
  );

  modport slave (
    input  tick_en, req, req_len,
    output grant, busy, count_out, done, done_id
  );
endinterface

// File: rtl/tick_timer_arbiter_rr.sv
// Combinational round-robin picker: selects the first set request at or
// above ptr, wrapping to the lowest set request when none is found above.
module rr_arbiter
  import tick_timer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_onehot_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_o
);

  logic [NREQ-1:0]     mask_s;
  logic [NREQ-1:0]     hi_s;
  logic [NREQ-1:0]     pick_s;
  logic [MAX_NREQ-1:0] oh_wide_s;

  // Isolate the lowest set bit of the requests at/above ptr, else of all requests.
  always_comb begin
    mask_s       = ~((NREQ'(1) << ptr_i) - NREQ'(1));
    hi_s         = req_i & mask_s;
    pick_s       = (hi_s != {NREQ{1'b0}}) ? hi_s : req_i;
    gnt_onehot_o = pick_s & (~pick_s + NREQ'(1));
    any_o        = |req_i;
    oh_wide_s    = MAX_NREQ'(gnt_onehot_o);
    gnt_idx_o    = IDW'(onehot2idx(oh_wide_s));
  end

endmodule

// File: rtl/tick_timer_arbiter.sv
// Shared interval timer: grants one modulo tick counter round-robin among
// NREQ requesters, counts LEN tick_en strobes for the owner, then pulses
// done with the owner's index. A dropped owner request aborts the interval.
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int CNT_WIDTH = 4,
  parameter int IDW       = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  tick_timer_arbiter_if.slave bus
);

  state_e               state_q;
  logic [IDW-1:0]       ptr_q;
  logic [IDW-1:0]       owner_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [NREQ-1:0]      grant_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 done_q;
  logic [IDW-1:0]       done_id_q;

  logic [NREQ-1:0]      arb_onehot_s;
  logic [IDW-1:0]       arb_idx_s;
  logic                 arb_any_s;
  logic [CNT_WIDTH-1:0] raw_len_s;
  logic [CNT_WIDTH-1:0] win_len_d;
  logic [CNT_WIDTH-1:0] last_cnt_s;
  logic [IDW-1:0]       ptr_d;
  logic                 owner_req_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i        (bus.req),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (arb_onehot_s),
    .gnt_idx_o    (arb_idx_s),
    .any_o        (arb_any_s)
  );

  // Winner's length (zero maps to one), terminal count, next pointer, owner request.
  always_comb begin
    raw_len_s   = bus.req_len[int'(arb_idx_s)*CNT_WIDTH +: CNT_WIDTH];
    win_len_d   = (raw_len_s == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1) : raw_len_s;
    last_cnt_s  = len_q - CNT_WIDTH'(1);
    ptr_d       = (owner_q == IDW'(NREQ - 1)) ? {IDW{1'b0}} : owner_q + IDW'(1);
    owner_req_s = bus.req[owner_q];
  end

  // Arbitration FSM with counter, pointer and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= {IDW{1'b0}};
      owner_q   <= {IDW{1'b0}};
      len_q     <= {CNT_WIDTH{1'b0}};
      grant_q   <= {NREQ{1'b0}};
      busy_q    <= 1'b0;
      count_q   <= {CNT_WIDTH{1'b0}};
      done_q    <= 1'b0;
      done_id_q <= {IDW{1'b0}};
    end else begin
      done_q    <= 1'b0;
      done_id_q <= {IDW{1'b0}};
      case (state_q)
        S_IDLE: begin
          if (arb_any_s) begin
            owner_q <= arb_idx_s;
            grant_q <= arb_onehot_s;
            len_q   <= win_len_d;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!owner_req_s) begin
            // Owner withdrew: release without done, still skip past it.
            state_q <= S_IDLE;
            grant_q <= {NREQ{1'b0}};
            busy_q  <= 1'b0;
            count_q <= {CNT_WIDTH{1'b0}};
            ptr_q   <= ptr_d;
          end else begin
            count_q <= {CNT_WIDTH{1'b0}};
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!owner_req_s) begin
            state_q <= S_IDLE;
            grant_q <= {NREQ{1'b0}};
            busy_q  <= 1'b0;
            count_q <= {CNT_WIDTH{1'b0}};
            ptr_q   <= ptr_d;
          end else if (bus.tick_en) begin
            if (count_q == last_cnt_s) begin
              state_q   <= S_DONE;
              count_q   <= {CNT_WIDTH{1'b0}};
              done_q    <= 1'b1;
              done_id_q <= owner_q;
            end else begin
              count_q <= count_q + CNT_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          grant_q <= {NREQ{1'b0}};
          busy_q  <= 1'b0;
          count_q <= {CNT_WIDTH{1'b0}};
          ptr_q   <= ptr_d;
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= {NREQ{1'b0}};
          busy_q  <= 1'b0;
          count_q <= {CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.count_out = count_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Directed bench for tick_timer_arbiter: expected owners are queued when
// requests are driven and popped when done pulses.
module tb_tick_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int CNT_W = 4;
  localparam int IDW   = 2;

  logic clk;
  logic reset_n;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   fail_cnt  = 0;
  bit   gate3     = 1'b0;
  logic last_tick = 1'b0;
  int   phase     = 0;
  int   exp_q[$];

  tick_timer_arbiter_if #(.NREQ(NREQ), .CNT_WIDTH(CNT_W), .IDW(IDW)) bus ();

  tick_timer_arbiter #(.NREQ(NREQ), .CNT_WIDTH(CNT_W), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Never more than one grant bit at any sampled point.
  always @(negedge clk) begin
    if (reset_n) chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
  end

  task automatic step();
    last_tick = bus.tick_en;
    @(negedge clk);
    phase++;
    if (gate3) bus.tick_en = (phase % 3 == 0);
  endtask

  task automatic set_len(input int i, input logic [3:0] v);
    bus.req_len[i*CNT_W +: CNT_W] = v;
  endtask

  task automatic check_done(input string tag);
    int exp_id;
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    if (exp_q.size() != 0) begin
      exp_id = exp_q.pop_front();
      chk({tag, "_done_id"}, 32'(bus.done_id), 32'(exp_id));
    end else begin
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.grant == '0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_granted"}, 32'(bus.grant != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    check_done(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.count_out), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_done_id", 32'(bus.done_id), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int        cyc;
    int        strobes;
    bit        finished;
    int        ord[4];
    logic [3:0] eg;

    reset_n     = 1'b0;
    bus.tick_en = 1'b0;
    bus.req     = '0;
    bus.req_len = '0;
    do_reset();

    // 1: single request, LEN=3, latched length ignores later changes
    bus.tick_en = 1'b1;
    set_len(0, 4'd3);
    bus.req = 4'b0001;
    exp_q.push_back(0);
    step();
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_done_early", 32'(bus.done), 32'd0);
    set_len(0, 4'd15);
    step();
    chk("t1_cnt0", 32'(bus.count_out), 32'd0);
    step();
    chk("t1_cnt1", 32'(bus.count_out), 32'd1);
    step();
    chk("t1_cnt2", 32'(bus.count_out), 32'd2);
    chk("t1_not_done", 32'(bus.done), 32'd0);
    step();
    check_done("t1");
    chk("t1_grant_at_done", 32'(bus.grant), 32'h1);
    chk("t1_cnt_wrap", 32'(bus.count_out), 32'd0);
    bus.req = 4'b0000;
    step();
    chk("t1_idle_grant", 32'(bus.grant), 32'd0);
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);
    chk("t1_idle_done", 32'(bus.done), 32'd0);

    // 2: contention from reset, owners alternate 1,3,1,3
    do_reset();
    set_len(1, 4'd2);
    set_len(3, 4'd2);
    ord = '{1, 3, 1, 3};
    for (int k = 0; k < 4; k++) exp_q.push_back(ord[k]);
    bus.req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      eg = 4'b0001 << ord[k];
      wait_grant($sformatf("t2_%0d", k), 6);
      chk($sformatf("t2_grant_%0d", k), 32'(bus.grant), 32'(eg));
      wait_done($sformatf("t2_%0d", k), 10, cyc);
      chk($sformatf("t2_latency_%0d", k), 32'(cyc), 32'd3);
      if (k == 3) bus.req = 4'b0000;
      step();
      chk($sformatf("t2_gap_%0d", k), 32'(bus.grant), 32'd0);
    end

    // 3: LEN=5 with tick_en on every third cycle
    set_len(2, 4'd5);
    bus.req = 4'b0100;
    exp_q.push_back(2);
    wait_grant("t3", 6);
    chk("t3_grant", 32'(bus.grant), 32'h4);
    gate3 = 1'b1;
    step();
    chk("t3_cnt0", 32'(bus.count_out), 32'd0);
    strobes  = 0;
    finished = 1'b0;
    for (int i = 0; i < 40 && !finished; i++) begin
      step();
      if (last_tick) strobes++;
      if (strobes == 5) begin
        check_done("t3");
        chk("t3_cnt_wrap", 32'(bus.count_out), 32'd0);
        finished = 1'b1;
      end else begin
        chk($sformatf("t3_nodone_%0d", i), 32'(bus.done), 32'd0);
        chk($sformatf("t3_cnt_%0d", i), 32'(bus.count_out), 32'(strobes));
      end
    end
    chk("t3_finished", 32'(bus.done), 32'd1);
    gate3       = 1'b0;
    bus.tick_en = 1'b1;
    bus.req     = 4'b0000;
    step();

    // 4: LEN=0 acts as LEN=1
    set_len(0, 4'd0);
    bus.req = 4'b0001;
    exp_q.push_back(0);
    wait_grant("t4", 6);
    chk("t4_grant", 32'(bus.grant), 32'h1);
    wait_done("t4", 10, cyc);
    chk("t4_latency", 32'(cyc), 32'd2);
    bus.req = 4'b0000;
    step();

    // 5: owner 1 aborts at count 2 of LEN=8; pointer moves past it
    set_len(1, 4'd8);
    set_len(2, 4'd1);
    bus.req = 4'b0110;
    wait_grant("t5", 6);
    chk("t5_grant", 32'(bus.grant), 32'h2);
    step();
    step();
    step();
    chk("t5_cnt2", 32'(bus.count_out), 32'd2);
    bus.req = 4'b0100;
    step();
    chk("t5_abort_grant", 32'(bus.grant), 32'd0);
    chk("t5_abort_busy", 32'(bus.busy), 32'd0);
    chk("t5_abort_done", 32'(bus.done), 32'd0);
    bus.req = 4'b0110;
    exp_q.push_back(2);
    step();
    chk("t5_next_grant", 32'(bus.grant), 32'h4);
    wait_done("t5", 10, cyc);
    chk("t5_latency", 32'(cyc), 32'd2);
    bus.req = 4'b0000;
    step();

    // 6: reset in the middle of a run clears outputs and the pointer
    set_len(0, 4'd1);
    set_len(3, 4'd8);
    bus.req = 4'b1001;
    wait_grant("t6", 6);
    chk("t6_grant", 32'(bus.grant), 32'h8);
    for (int i = 0; i < 5; i++) step();
    chk("t6_cnt4", 32'(bus.count_out), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(bus.grant), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    chk("t6_async_count", 32'(bus.count_out), 32'd0);
    chk("t6_async_done", 32'(bus.done), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    exp_q.push_back(0);
    wait_grant("t6_restart", 6);
    chk("t6_restart_grant", 32'(bus.grant), 32'h1);
    wait_done("t6", 10, cyc);
    chk("t6_latency", 32'(cyc), 32'd2);
    bus.req = 4'b0000;
    step();
    chk("t6_end_busy", 32'(bus.busy), 32'd0);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
